// File: rtl/clock_alarm_core_if.sv
// Control/status bundle for clock_alarm_core: time/alarm presets, alarm controls,
// and the registered time and annunciator outputs.
interface clock_alarm_core_if #(
  parameter int unsigned SEC_W = 6,
  parameter int unsigned MIN_W = 6,
  parameter int unsigned HR_W  = 5
);
  logic             ena;
  logic             load;
  logic [HR_W-1:0]  load_hr;
  logic [MIN_W-1:0] load_min;
  logic [SEC_W-1:0] load_sec;
  logic             alarm_set;
  logic [HR_W-1:0]  alarm_hr;
  logic [MIN_W-1:0] alarm_min;
  logic             arm;
  logic             ack;
  logic             snooze;
  logic [HR_W-1:0]  hours;
  logic [MIN_W-1:0] minutes;
  logic [SEC_W-1:0] seconds;
  logic             tick;
  logic             alarm;
  logic             snoozed;

  modport master (
    output ena, load, load_hr, load_min, load_sec,
    output alarm_set, alarm_hr, alarm_min, arm, ack, snooze,
    input  hours, minutes, seconds, tick, alarm, snoozed
  );

  modport slave (
    input  ena, load, load_hr, load_min, load_sec,
    input  alarm_set, alarm_hr, alarm_min, arm, ack, snooze,
    output hours, minutes, seconds, tick, alarm, snoozed
  );
endinterface

// File: rtl/clock_alarm_core.sv
// H:M:S real-time clock with prescaled tick, presets and an armed alarm FSM.
// Define CLOCKALARM_SNOOZE_EN to build the SNOOZED state and snooze target logic.
module clock_alarm_core #(
  parameter int unsigned TICK_DIV   = 1,
  parameter int unsigned SEC_MOD    = 60,
  parameter int unsigned MIN_MOD    = 60,
  parameter int unsigned HR_MOD     = 24,
  parameter int unsigned SEC_W      = 6,
  parameter int unsigned MIN_W      = 6,
  parameter int unsigned HR_W       = 5,
  parameter int unsigned RING_LEN   = 60,
  parameter int unsigned SNOOZE_MIN = 5
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  clock_alarm_core_if.slave bus
);
  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned RW = (RING_LEN > 1) ? $clog2(RING_LEN) : 1;
  localparam logic [PW-1:0]    PRE_LAST  = PW'(TICK_DIV - 1);
  localparam logic [SEC_W-1:0] SEC_LAST  = SEC_W'(SEC_MOD - 1);
  localparam logic [MIN_W-1:0] MIN_LAST  = MIN_W'(MIN_MOD - 1);
  localparam logic [HR_W-1:0]  HR_LAST   = HR_W'(HR_MOD - 1);
  localparam logic [RW-1:0]    RING_LAST = RW'(RING_LEN - 1);

`ifdef CLOCKALARM_SNOOZE_EN
  typedef enum logic [1:0] {IDLE, RINGING, SNOOZED} state_e;
`else
  typedef enum logic {IDLE, RINGING} state_e;
`endif

  state_e           state_q, state_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic [SEC_W-1:0] sec_q, sec_d, sec_adv, ld_sec;
  logic [MIN_W-1:0] min_q, min_d, min_adv, ld_min;
  logic [HR_W-1:0]  hr_q, hr_d, hr_adv, ld_hr;
  logic [HR_W-1:0]  alm_hr_q;
  logic [MIN_W-1:0] alm_min_q;
  logic [RW-1:0]    ring_q, ring_d;
  logic             tick_q, alarm_q;
  logic             adv, alm_hit;

  // A load on the same edge swallows the advance and restarts the prescaler.
  assign adv = bus.ena && !bus.load && (pre_q == PRE_LAST);

  assign ld_sec = ({1'b0, bus.load_sec} >= (SEC_W+1)'(SEC_MOD)) ? '0 : bus.load_sec;
  assign ld_min = ({1'b0, bus.load_min} >= (MIN_W+1)'(MIN_MOD)) ? '0 : bus.load_min;
  assign ld_hr  = ({1'b0, bus.load_hr}  >= (HR_W+1)'(HR_MOD))   ? '0 : bus.load_hr;

  always_comb begin
    sec_adv = sec_q + 1'b1;
    min_adv = min_q;
    hr_adv  = hr_q;
    if (sec_q == SEC_LAST) begin
      sec_adv = '0;
      min_adv = min_q + 1'b1;
      if (min_q == MIN_LAST) begin
        min_adv = '0;
        hr_adv  = (hr_q == HR_LAST) ? '0 : hr_q + 1'b1;
      end
    end
  end

  always_comb begin
    pre_d = pre_q;
    sec_d = sec_q;
    min_d = min_q;
    hr_d  = hr_q;
    if (bus.load) begin
      pre_d = '0;
      sec_d = ld_sec;
      min_d = ld_min;
      hr_d  = ld_hr;
    end else if (bus.ena) begin
      pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
      if (adv) begin
        sec_d = sec_adv;
        min_d = min_adv;
        hr_d  = hr_adv;
      end
    end
  end

  assign alm_hit = adv && bus.arm && (sec_adv == '0) &&
                   (min_adv == alm_min_q) && (hr_adv == alm_hr_q);

`ifdef CLOCKALARM_SNOOZE_EN
  logic [HR_W-1:0]  snz_hr_q, snz_hr_d, tgt_hr;
  logic [MIN_W-1:0] snz_min_q, snz_min_d, tgt_min;
  logic [MIN_W:0]   min_sum;
  logic             snoozed_q, snz_hit;

  always_comb begin
    min_sum = {1'b0, min_q} + (MIN_W+1)'(SNOOZE_MIN);
    tgt_min = min_sum[MIN_W-1:0];
    tgt_hr  = hr_q;
    if (min_sum >= (MIN_W+1)'(MIN_MOD)) begin
      tgt_min = MIN_W'(min_sum - (MIN_W+1)'(MIN_MOD));
      tgt_hr  = (hr_q == HR_LAST) ? '0 : hr_q + 1'b1;
    end
  end

  assign snz_hit = adv && bus.arm && (sec_adv == '0) &&
                   (min_adv == snz_min_q) && (hr_adv == snz_hr_q);
`else
  localparam int unsigned unused_snooze_min = SNOOZE_MIN;
  logic unused_snooze;
  assign unused_snooze = bus.snooze;
`endif

  always_comb begin
    state_d = state_q;
    ring_d  = ring_q;
`ifdef CLOCKALARM_SNOOZE_EN
    snz_hr_d  = snz_hr_q;
    snz_min_d = snz_min_q;
`endif
    case (state_q)
      IDLE: begin
        if (alm_hit) begin
          state_d = RINGING;
          ring_d  = '0;
        end
      end
      RINGING: begin
        if (bus.ack || !bus.arm) begin
          state_d = IDLE;
`ifdef CLOCKALARM_SNOOZE_EN
        end else if (bus.snooze) begin
          state_d   = SNOOZED;
          snz_hr_d  = tgt_hr;
          snz_min_d = tgt_min;
`endif
        end else if (adv) begin
          if (ring_q == RING_LAST) state_d = IDLE;
          else                     ring_d  = ring_q + 1'b1;
        end
      end
`ifdef CLOCKALARM_SNOOZE_EN
      SNOOZED: begin
        if (bus.ack || !bus.arm) begin
          state_d = IDLE;
        end else if (snz_hit) begin
          state_d = RINGING;
          ring_d  = '0;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      pre_q     <= '0;
      sec_q     <= '0;
      min_q     <= '0;
      hr_q      <= '0;
      alm_hr_q  <= '0;
      alm_min_q <= '0;
      ring_q    <= '0;
      tick_q    <= 1'b0;
      alarm_q   <= 1'b0;
`ifdef CLOCKALARM_SNOOZE_EN
      snz_hr_q  <= '0;
      snz_min_q <= '0;
      snoozed_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hr_q    <= hr_d;
      ring_q  <= ring_d;
      tick_q  <= adv;
      alarm_q <= (state_d == RINGING);
`ifdef CLOCKALARM_SNOOZE_EN
      snz_hr_q  <= snz_hr_d;
      snz_min_q <= snz_min_d;
      snoozed_q <= (state_d == SNOOZED);
`endif
      if (bus.alarm_set) begin
        alm_hr_q  <= bus.alarm_hr;
        alm_min_q <= bus.alarm_min;
      end
    end
  end

  assign bus.hours   = hr_q;
  assign bus.minutes = min_q;
  assign bus.seconds = sec_q;
  assign bus.tick    = tick_q;
  assign bus.alarm   = alarm_q;
`ifdef CLOCKALARM_SNOOZE_EN
  assign bus.snoozed = snoozed_q;
`else
  assign bus.snoozed = 1'b0;
`endif
endmodule

// File: doc/clock_alarm_core.md
# clock_alarm_core

Parametrised real-time clock with a programmable alarm. Counts hours:minutes:seconds with configurable moduli, derives the one-second tick from a prescaler on the system clock, and supports preset loading of both time and alarm. A ringing/snooze state machine drives the alarm output; the block sits between the board-level clock input and the display/annunciator logic.

## Interface
- `TICK_DIV`, 1: clk cycles per second tick (≥1).
- `SEC_MOD`, 60: seconds modulus.
- `MIN_MOD`, 60: minutes modulus.
- `HR_MOD`, 24: hours modulus.
- `SEC_W` / `MIN_W` / `HR_W`, 6 / 6 / 5: field widths. Each field width must satisfy 2^W ≥ MOD.
- `RING_LEN`, 60: ticks the alarm rings before it self-clears (≥1).
- `SNOOZE_MIN`, 5: snooze delay in minutes (1..MIN_MOD-1).

- `clk`  in  1  system clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `ena`  in  1  count enable. Low freezes the prescaler, the time, and the ring timer.
- `load`  in  1  one-cycle strobe. Loads `load_hr`/`load_min`/`load_sec` into the time.
- `load_hr`, `load_min`, `load_sec`  in  HR_W/MIN_W/SEC_W  preset time.
- `alarm_set`  in  1  one-cycle strobe. Latches `alarm_hr`/`alarm_min`.
- `alarm_hr`, `alarm_min`  in  HR_W/MIN_W  alarm time.
- `arm`  in  1  level. Alarm is enabled while high.
- `ack`  in  1  dismiss.
- `snooze`  in  1  snooze request.
- `hours`, `minutes`, `seconds`  out  HR_W/MIN_W/SEC_W  current time (registered).
- `tick`  out  1  registered. High for one cycle, coincident with each time advance.
- `alarm`  out  1  registered. High in the RINGING state.
- `snoozed`  out  1  registered. High in the SNOOZED state.

## Operation
- **Reset** (rst_n low at a clk edge):
  - Time = 0:0:0; prescaler = 0; alarm registers = 0:0.
  - FSM = IDLE; tick = alarm = snoozed = 0.
- **Priority, per edge:** reset > load > tick advance.
- **Prescaler:** counts 0..TICK_DIV-1 while ena is high. An advance occurs on the edge where the count equals TICK_DIV-1; the count then returns to 0.
- **Advance:**
  - Seconds increment; on SEC_MOD-1 they wrap to 0 and carry into minutes.
  - Minutes wrap at MIN_MOD-1 and carry into hours; hours wrap at HR_MOD-1.
  - Full rollover: (HR_MOD-1):(MIN_MOD-1):(SEC_MOD-1) → 0:0:0.
- **Load:**
  - Any field ≥ its modulus loads 0.
  - Prescaler clears; tick stays 0 that cycle.
  - Load never triggers the alarm.
- **Alarm match:** an advance that produces alarm_hr:alarm_min:00 while arm is high.
- **FSM:**
  - IDLE → RINGING on match.
  - RINGING → IDLE on ack, on arm low, or after RING_LEN ticks (ring timer clears on entry and counts advances only).
  - RINGING → SNOOZED on snooze. The snooze target is (current hours:minutes + SNOOZE_MIN minutes, :00), with minute wrap carrying into hours mod HR_MOD.
  - SNOOZED → RINGING on an advance that produces the target, provided arm is high.
  - SNOOZED → IDLE on ack or arm low.
  - ack and snooze together: ack wins.
- **alarm_set** updates the compare registers in any state and does not alter the current state.

## Timing
- Time, tick, alarm and snoozed all update on the same edge. Alarm rises on the edge where the matching time appears.
- ack/snooze/arm take effect at the next edge; outputs change 1 cycle after the request is sampled.
- With TICK_DIV=1 and ena held high, the time advances every cycle.
- A load coincident with a would-be advance discards the advance.
- Reset mid-ring clears alarm on that edge.

## Configuration
- `CLOCKALARM_SNOOZE_EN` defined:
  - SNOOZED state, snooze target registers and the `snoozed` output are implemented as above.
- Undefined:
  - The `snooze` input is ignored and `snoozed` is tied to 0.
  - The FSM has only IDLE and RINGING.

## Test plan
All scenarios use TICK_DIV=1, SEC_MOD=4, MIN_MOD=8, HR_MOD=4, RING_LEN=3, SNOOZE_MIN=2 unless stated.

1. **Reset and full wrap:** reset, then ena=1 for 128 cycles → time returns to 0:0:0; tick high every cycle; 3:7:3 → 0:0:0 in one edge.
2. **Prescaler:** TICK_DIV=5, ena=1 → tick every 5th cycle. ena low for 3 cycles → no advance; the count resumes from its held value.
3. **Load:** load 2:9:1 → time becomes 2:0:1, no tick that cycle. Load 1:2:0 with alarm 1:2 armed → alarm stays 0.
4. **Ring and timeout:** alarm 0:3 armed from 0:0:0 → alarm rises on the edge showing 0:3:0, stays high 3 ticks, and falls on the edge showing 0:3:3. ack mid-ring → alarm 0 next cycle.
5. **Snooze (SNOOZE_EN):**
   - snooze at 0:3:1 → snoozed=1, alarm=0; re-ring at 0:5:0.
   - Target wraps: snooze at 3:7:x → target 0:1:0.
   - ack+snooze together → IDLE.
6. **Arm drop and no-snooze build:**
   - arm low while RINGING → alarm 0 next cycle.
   - Without the macro, snooze while ringing → alarm remains high; snoozed=0 throughout.
